// File: rtl/instr_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_pkg
// Shared constants for the byte-stream program loader:
//   - memory geometry (word length, cell size, default instruction memory size)
//   - default frame sync marker
//   - FSM state encodings
//   - header validation helpers
// Optional feature macro used by the loader: INSTR_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package instr_mem_loader_pkg;

  localparam int WORD_LEN       = 32;
  localparam int MEM_CELL_SIZE  = 8;
  localparam int INSTR_MEM_SIZE = 1024;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  // Loader FSM states (nine states, so four bits are needed)
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_AH   = 4'd1;
  localparam logic [3:0] ST_AL   = 4'd2;
  localparam logic [3:0] ST_CH   = 4'd3;
  localparam logic [3:0] ST_CL   = 4'd4;
  localparam logic [3:0] ST_DATA = 4'd5;
  localparam logic [3:0] ST_CHK  = 4'd6;
  localparam logic [3:0] ST_DONE = 4'd7;
  localparam logic [3:0] ST_ERR  = 4'd8;

  // Decoded frame header
  typedef struct packed {
    logic [15:0] start;
    logic [15:0] count;
  } frame_hdr_t;

  // Start address must be word aligned
  function automatic logic hdr_aligned(input frame_hdr_t hdr);
    return (hdr.start[1:0] == 2'b00);
  endfunction

  // start + 4*count must not exceed the memory; computed wide so it never wraps
  function automatic logic hdr_fits(input frame_hdr_t hdr, input int mem_size);
    logic [18:0] end_v;
    end_v = {3'b000, hdr.start} + {1'b0, hdr.count, 2'b00};
    return (end_v <= 19'(mem_size));
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_if
// Bundles the loader's stream handshake and instruction-memory write bus.
//   in_valid/in_data/in_ready : byte stream (valid/ready)
//   mem_we/mem_addr/mem_data  : one-byte-per-cycle memory write
//   cpu_hold/done/err         : core hold and frame status pulses
// Modports: slave (the loader), master (the stream source / observer).
// -----------------------------------------------------------------------------
interface instr_mem_loader_if #(
  parameter int MEM_SIZE = 1024
);
  import instr_mem_loader_pkg::*;

  localparam int ADDR_W = $clog2(MEM_SIZE);

  logic                     in_valid;
  logic [MEM_CELL_SIZE-1:0] in_data;
  logic                     in_ready;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [MEM_CELL_SIZE-1:0] mem_data;
  logic                     cpu_hold;
  logic                     done;
  logic                     err;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, err
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, err
  );

endinterface

// File: rtl/instr_mem_loader_checksum.sv
// -----------------------------------------------------------------------------
// loader_checksum
// XOR accumulator over the payload bytes of a frame. Only compiled when
// INSTR_LOADER_CHECKSUM_EN is defined (the loader instantiates it only then).
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : clear the accumulator (start of a frame)
//   en_i     : fold data_i into the accumulator
//   data_i   : payload byte
//   sum_o    : running XOR
// -----------------------------------------------------------------------------
`ifdef INSTR_LOADER_CHECKSUM_EN
module loader_checksum
  import instr_mem_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic [MEM_CELL_SIZE-1:0] data_i,
  output logic [MEM_CELL_SIZE-1:0] sum_o
);

  logic [MEM_CELL_SIZE-1:0] sum_q;

  // Running XOR, cleared at frame start (clear wins over enable)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_q ^ data_i;
    end else begin
      sum_q <= sum_q;
    end
  end

  assign sum_o = sum_q;

endmodule
`endif

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Write side of the byte-addressed, big-endian instruction memory. Parses a
// framed byte stream
//   SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, 4*CNT payload bytes [, XOR byte]
// and writes each payload byte to consecutive addresses, one cycle after it
// is accepted. The core is held in reset (cpu_hold) while a frame is active.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instr_mem_loader_if.slave (stream in, memory write out, status)
// Parameters: MEM_SIZE (bytes, power of 2), SYNC_BYTE (frame start marker).
// Optional feature: INSTR_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
// -----------------------------------------------------------------------------
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int         MEM_SIZE  = INSTR_MEM_SIZE,
  parameter logic [7:0] SYNC_BYTE = LOADER_SYNC_BYTE
) (
  input logic               clk,
  input logic               rst,
  instr_mem_loader_if.slave bus
);

  localparam int ADDR_W = $clog2(MEM_SIZE);

  // Where the frame goes once the payload (or an empty header) is finished
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam logic [3:0] ST_END = ST_CHK;
`else
  localparam logic [3:0] ST_END = ST_DONE;
`endif

  logic [3:0]               state_q,    state_d;
  logic [7:0]               addr_hi_q,  addr_hi_d;
  logic [15:0]              start_q,    start_d;
  logic [7:0]               cnt_hi_q,   cnt_hi_d;
  logic [ADDR_W-1:0]        ptr_q,      ptr_d;
  logic [17:0]              left_q,     left_d;
  logic                     in_ready_q, in_ready_d;
  logic                     mem_we_q,   mem_we_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [MEM_CELL_SIZE-1:0] mem_data_q, mem_data_d;
  logic                     cpu_hold_q, cpu_hold_d;
  logic                     done_q,     done_d;
  logic                     err_q,      err_d;

  logic       xfer_s;
  frame_hdr_t hdr_s;

  assign xfer_s = bus.in_valid && in_ready_q;
  // Header as it stands when the CL byte is on the bus
  assign hdr_s  = '{start: start_q, count: {cnt_hi_q, bus.in_data}};

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic                     chk_clr_s;
  logic                     chk_en_s;
  logic [MEM_CELL_SIZE-1:0] chk_sum_s;

  assign chk_clr_s = xfer_s && (state_q == ST_IDLE) && (bus.in_data == SYNC_BYTE);
  assign chk_en_s  = xfer_s && (state_q == ST_DATA);

  loader_checksum u_checksum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (chk_clr_s),
    .en_i   (chk_en_s),
    .data_i (bus.in_data),
    .sum_o  (chk_sum_s)
  );
`endif

  // Next-state, header capture and write-pipeline logic
  always_comb begin
    state_d    = state_q;
    addr_hi_d  = addr_hi_q;
    start_d    = start_q;
    cnt_hi_d   = cnt_hi_q;
    ptr_d      = ptr_q;
    left_d     = left_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    case (state_q)
      ST_IDLE: begin
        // Anything other than the sync marker is consumed and dropped
        if (xfer_s && (bus.in_data == SYNC_BYTE)) begin
          state_d = ST_AH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AH: begin
        if (xfer_s) begin
          addr_hi_d = bus.in_data;
          state_d   = ST_AL;
        end else begin
          state_d   = ST_AH;
        end
      end
      ST_AL: begin
        if (xfer_s) begin
          start_d = {addr_hi_q, bus.in_data};
          state_d = ST_CH;
        end else begin
          state_d = ST_AL;
        end
      end
      ST_CH: begin
        if (xfer_s) begin
          cnt_hi_d = bus.in_data;
          state_d  = ST_CL;
        end else begin
          state_d  = ST_CH;
        end
      end
      ST_CL: begin
        if (xfer_s) begin
          if (!hdr_aligned(hdr_s) || !hdr_fits(hdr_s, MEM_SIZE)) begin
            state_d = ST_ERR;
          end else if (hdr_s.count == 16'd0) begin
            state_d = ST_END;
          end else begin
            ptr_d   = hdr_s.start[ADDR_W-1:0];
            left_d  = {hdr_s.count, 2'b00};
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_CL;
        end
      end
      ST_DATA: begin
        // Registered write: appears on the bus the cycle after acceptance
        if (xfer_s) begin
          mem_we_d   = 1'b1;
          mem_addr_d = ptr_q;
          mem_data_d = bus.in_data;
          ptr_d      = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          left_d     = left_q - 18'd1;
          if (left_q == 18'd1) begin
            state_d = ST_END;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer_s) begin
          if (bus.in_data == chk_sum_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_CHK;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered copies decoded from the next state
  always_comb begin
    in_ready_d = (state_d != ST_DONE) && (state_d != ST_ERR);
    cpu_hold_d = (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ERR);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
  end

  // State, header and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_hi_q  <= 8'h00;
      start_q    <= 16'h0000;
      cnt_hi_q   <= 8'h00;
      ptr_q      <= '0;
      left_q     <= 18'd0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_hi_q  <= addr_hi_d;
      start_q    <= start_d;
      cnt_hi_q   <= cnt_hi_d;
      ptr_q      <= ptr_d;
      left_q     <= left_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule
